// File: rtl/valve_drive_sequencer.sv
// Valve drive sequencer: staggered valve openings, minimum off time, fault shutdown.
// Optional max-on watchdog enabled by defining VALVE_DRV_WDOG_EN.
module valve_drive_sequencer #(
  parameter int unsigned NUM_VALVES  = 4,
  parameter int unsigned STAGGER_CYC = 8,
  parameter int unsigned MIN_OFF_CYC = 16,
  parameter int unsigned MAX_ON_CYC  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_VALVES-1:0] req,
  input  logic                  fault_in,
  input  logic                  fault_clr,
  output logic [NUM_VALVES-1:0] valve_on,
  output logic [NUM_VALVES-1:0] timeout,
  output logic                  fault_latched,
  output logic                  busy
);

  localparam int unsigned STAG_W = $clog2(STAGGER_CYC + 1);
  localparam int unsigned OFF_W  = $clog2(MIN_OFF_CYC + 1);

  typedef enum logic [1:0] {
    CLOSED   = 2'd0,
    PENDING  = 2'd1,
    OPEN     = 2'd2,
    COOLDOWN = 2'd3
  } ch_state_t;

  ch_state_t             state     [NUM_VALVES];
  ch_state_t             state_nxt [NUM_VALVES];
  logic [OFF_W-1:0]      off_cnt     [NUM_VALVES];
  logic [OFF_W-1:0]      off_cnt_nxt [NUM_VALVES];
  logic [STAG_W-1:0]     stagger_cnt;
  logic [STAG_W-1:0]     stagger_nxt;
  logic                  fault_nxt;
  logic                  fault_any;
  logic                  granted;
  logic [NUM_VALVES-1:0] valve_on_nxt;
  logic                  busy_nxt;
  logic [NUM_VALVES-1:0] timeout_nxt;

`ifdef VALVE_DRV_WDOG_EN
  localparam int unsigned ON_W = $clog2(MAX_ON_CYC + 1);
  logic [ON_W-1:0]       on_cnt     [NUM_VALVES];
  logic [ON_W-1:0]       on_cnt_nxt [NUM_VALVES];
  logic [NUM_VALVES-1:0] timeout_q;

  assign timeout = timeout_q;
`else
  assign timeout = '0;
`endif

  assign fault_any = fault_in | fault_latched;

  // Next-state logic for all channels, the shared stagger slot and the fault latch
  always_comb begin
    stagger_nxt  = stagger_cnt;
    fault_nxt    = fault_in | (fault_latched & ~fault_clr);
    granted      = 1'b0;
    valve_on_nxt = '0;
    busy_nxt     = 1'b0;
    timeout_nxt  = '0;
    for (int i = 0; i < int'(NUM_VALVES); i++) begin
      state_nxt[i]   = state[i];
      off_cnt_nxt[i] = off_cnt[i];
`ifdef VALVE_DRV_WDOG_EN
      on_cnt_nxt[i]  = on_cnt[i];
      timeout_nxt[i] = req[i] & timeout_q[i];
`endif
    end

    for (int i = 0; i < int'(NUM_VALVES); i++) begin
      case (state[i])
        CLOSED: begin
          if (req[i] && !timeout[i] && !fault_any) state_nxt[i] = PENDING;
        end
        PENDING: begin
          if (!req[i] || fault_any) begin
            state_nxt[i] = CLOSED;
          end else if (!granted && stagger_cnt == '0) begin
            // Loop order gives the lowest pending index the slot
            state_nxt[i] = OPEN;
            granted      = 1'b1;
`ifdef VALVE_DRV_WDOG_EN
            on_cnt_nxt[i] = '0;
`endif
          end
        end
        OPEN: begin
          if (!req[i] || fault_any) begin
            state_nxt[i]   = COOLDOWN;
            off_cnt_nxt[i] = '0;
          end
`ifdef VALVE_DRV_WDOG_EN
          else if (on_cnt[i] == ON_W'(MAX_ON_CYC - 1)) begin
            state_nxt[i]   = COOLDOWN;
            off_cnt_nxt[i] = '0;
            timeout_nxt[i] = 1'b1;
          end else begin
            on_cnt_nxt[i] = on_cnt[i] + ON_W'(1);
          end
`endif
        end
        COOLDOWN: begin
          if (off_cnt[i] == OFF_W'(MIN_OFF_CYC - 1)) begin
            state_nxt[i] = CLOSED;
          end else if (off_cnt[i] < OFF_W'(MIN_OFF_CYC - 1)) begin
            off_cnt_nxt[i] = off_cnt[i] + OFF_W'(1);
          end
        end
        default: state_nxt[i] = CLOSED;
      endcase
    end

    if (granted) begin
      stagger_nxt = STAG_W'(STAGGER_CYC - 1);
    end else if (stagger_cnt != '0) begin
      stagger_nxt = stagger_cnt - STAG_W'(1);
    end

    for (int i = 0; i < int'(NUM_VALVES); i++) begin
      valve_on_nxt[i] = (state_nxt[i] == OPEN);
      busy_nxt        = busy_nxt | (state_nxt[i] != CLOSED);
    end
  end

  // State and registered outputs; reset closes every valve immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_VALVES); i++) begin
        state[i]   <= CLOSED;
        off_cnt[i] <= '0;
      end
      stagger_cnt   <= '0;
      fault_latched <= 1'b0;
      valve_on      <= '0;
      busy          <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_VALVES); i++) begin
        state[i]   <= state_nxt[i];
        off_cnt[i] <= off_cnt_nxt[i];
      end
      stagger_cnt   <= stagger_nxt;
      fault_latched <= fault_nxt;
      valve_on      <= valve_on_nxt;
      busy          <= busy_nxt;
    end
  end

`ifdef VALVE_DRV_WDOG_EN
  // Per-channel on-timers and sticky trip flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_VALVES); i++) on_cnt[i] <= '0;
      timeout_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_VALVES); i++) on_cnt[i] <= on_cnt_nxt[i];
      timeout_q <= timeout_nxt;
    end
  end
`else
  logic unused_timeout_nxt;
  assign unused_timeout_nxt = ^timeout_nxt;
`endif

endmodule
